// File: rtl/cgra_ctrl_pkg.sv
// Shared definitions for the CGRA host-side config sequencer: sequencer states,
// default field widths and the config-entry layout at those widths.
package cgra_ctrl_pkg;

  localparam int PE_ROW_W    = 2;
  localparam int PE_COL_W    = 2;
  localparam int NBR_SEL_W   = 3;
  localparam int OP_W        = 4;
  localparam int DATA_W      = 32;
  localparam int CTX_W       = 4;
  localparam int ENTRY_CNT_W = 8;
  localparam int RUN_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // Same field order as the CGRA config_data struct.
  typedef struct packed {
    logic [PE_ROW_W-1:0]  row;
    logic [PE_COL_W-1:0]  col;
    logic [NBR_SEL_W-1:0] in1;
    logic [NBR_SEL_W-1:0] in2;
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    const_data;
    logic [CTX_W-1:0]     ctx;
  } cfg_entry_t;

endpackage

// File: rtl/cgra_config_sequencer.sv
// Host-side job sequencer: takes one job command, streams its config entries into
// the CGRA config-load port, then holds start_exec for the requested run length.
module cgra_config_sequencer
  import cgra_ctrl_pkg::*;
#(
  parameter int PE_ROW_BIT_LENGTH          = PE_ROW_W,
  parameter int PE_COLUMN_BIT_LENGTH       = PE_COL_W,
  parameter int NEIGHBOR_PE_NUM_BIT_LENGTH = NBR_SEL_W,
  parameter int OPERATION_BIT_LENGTH       = OP_W,
  parameter int DATA_WIDTH                 = DATA_W,
  parameter int CONTEXT_SIZE_BIT_LENGTH    = CTX_W,
  parameter int ENTRY_CNT_WIDTH            = ENTRY_CNT_W,
  parameter int RUN_CNT_WIDTH              = RUN_CNT_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [ENTRY_CNT_WIDTH-1:0]            cmd_entry_count,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cmd_context_max_id,
  input  logic [RUN_CNT_WIDTH-1:0]              cmd_run_cycles,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [PE_ROW_BIT_LENGTH-1:0]          cfg_row,
  input  logic [PE_COLUMN_BIT_LENGTH-1:0]       cfg_col,
  input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_in1,
  input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_in2,
  input  logic [OPERATION_BIT_LENGTH-1:0]       cfg_op,
  input  logic [DATA_WIDTH-1:0]                 cfg_const,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    cfg_context,
  input  logic                                  abort,
  output logic [PE_ROW_BIT_LENGTH-1:0]          config_PE_row_index,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]       config_PE_column_index,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_1,
  output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] config_input_PE_index_2,
  output logic [OPERATION_BIT_LENGTH-1:0]       config_op,
  output logic [DATA_WIDTH-1:0]                 config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    config_index,
  output logic                                  write_config_data,
  output logic                                  start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    mapping_context_max_id,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  aborted,
  output logic                                  cfg_error
);

  typedef struct packed {
    logic [PE_ROW_BIT_LENGTH-1:0]          row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]       col;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in1;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] in2;
    logic [OPERATION_BIT_LENGTH-1:0]       op;
    logic [DATA_WIDTH-1:0]                 const_data;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0]    ctx;
  } entry_t;

  seq_state_t                 state;
  entry_t                     cfg_in, cfg_q;
  logic [ENTRY_CNT_WIDTH-1:0] entry_left;
  logic [RUN_CNT_WIDTH-1:0]   run_left;
  logic                       cmd_fire, cfg_fire, ctx_ok, last_beat;

  assign cfg_in    = {cfg_row, cfg_col, cfg_in1, cfg_in2, cfg_op, cfg_const, cfg_context};
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign ctx_ok    = (cfg_context <= mapping_context_max_id);
  assign last_beat = (entry_left <= ENTRY_CNT_WIDTH'(1));

  assign config_PE_row_index     = cfg_q.row;
  assign config_PE_column_index  = cfg_q.col;
  assign config_input_PE_index_1 = cfg_q.in1;
  assign config_input_PE_index_2 = cfg_q.in2;
  assign config_op               = cfg_q.op;
  assign config_const_data       = cfg_q.const_data;
  assign config_index            = cfg_q.ctx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      cfg_q                  <= '0;
      entry_left             <= '0;
      run_left               <= '0;
      cmd_ready              <= 1'b0;
      cfg_ready              <= 1'b0;
      write_config_data      <= 1'b0;
      start_exec             <= 1'b0;
      mapping_context_max_id <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      aborted                <= 1'b0;
      cfg_error              <= 1'b0;
    end else begin
      write_config_data <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state      <= ST_IDLE;
        entry_left <= '0;
        run_left   <= '0;
        cfg_ready  <= 1'b0;
        start_exec <= 1'b0;
        busy       <= 1'b0;
        cmd_ready  <= 1'b1;
        aborted    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_fire && abort) begin
              aborted <= 1'b1;
            end else if (cmd_fire) begin
              entry_left             <= cmd_entry_count;
              run_left               <= cmd_run_cycles;
              mapping_context_max_id <= cmd_context_max_id;
              cfg_error              <= 1'b0;
              busy                   <= 1'b1;
              cmd_ready              <= 1'b0;
              if (cmd_entry_count != '0) begin
                state     <= ST_LOAD;
                cfg_ready <= 1'b1;
              end else if (cmd_run_cycles != '0) begin
                state <= ST_RUN;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            if (cfg_fire) begin
              // Out-of-range contexts still consume a beat but never reach the array.
              if (ctx_ok) begin
                cfg_q             <= cfg_in;
                write_config_data <= 1'b1;
              end else begin
                cfg_error <= 1'b1;
              end
              if (entry_left != '0) entry_left <= entry_left - 1'b1;
              if (last_beat) begin
                cfg_ready <= 1'b0;
                if (run_left != '0) begin
                  state <= ST_RUN;
                end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
          ST_RUN: begin
            // First RUN cycle is the strobe cycle; start_exec rises on the next one.
            if (run_left != '0) begin
              start_exec <= 1'b1;
              run_left   <= run_left - 1'b1;
            end else begin
              start_exec <= 1'b0;
              state      <= ST_DONE;
              done       <= 1'b1;
            end
          end
          ST_DONE: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Bench for cgra_config_sequencer: directed job table, random jobs against a
// transaction-level model, and hand-written abort/reset sequences.
module tb_cgra_config_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_entry_count;
  logic [3:0]  cmd_context_max_id;
  logic [15:0] cmd_run_cycles;
  logic        cfg_valid, cfg_ready;
  logic [1:0]  cfg_row, cfg_col;
  logic [2:0]  cfg_in1, cfg_in2;
  logic [3:0]  cfg_op;
  logic [31:0] cfg_const;
  logic [3:0]  cfg_context;
  logic        abort;
  logic [1:0]  config_PE_row_index, config_PE_column_index;
  logic [2:0]  config_input_PE_index_1, config_input_PE_index_2;
  logic [3:0]  config_op;
  logic [31:0] config_const_data;
  logic [3:0]  config_index;
  logic        write_config_data, start_exec;
  logic [3:0]  mapping_context_max_id;
  logic        busy, done, aborted, cfg_error;

  cgra_config_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_entry_count(cmd_entry_count), .cmd_context_max_id(cmd_context_max_id),
    .cmd_run_cycles(cmd_run_cycles),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_in1(cfg_in1), .cfg_in2(cfg_in2),
    .cfg_op(cfg_op), .cfg_const(cfg_const), .cfg_context(cfg_context),
    .abort(abort),
    .config_PE_row_index(config_PE_row_index), .config_PE_column_index(config_PE_column_index),
    .config_input_PE_index_1(config_input_PE_index_1), .config_input_PE_index_2(config_input_PE_index_2),
    .config_op(config_op), .config_const_data(config_const_data), .config_index(config_index),
    .write_config_data(write_config_data), .start_exec(start_exec),
    .mapping_context_max_id(mapping_context_max_id),
    .busy(busy), .done(done), .aborted(aborted), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [2:0]  in1;
    logic [2:0]  in2;
    logic [3:0]  op;
    logic [31:0] cdata;
    logic [3:0]  ctx;
  } bent_t;

  typedef struct {
    int   cnt;
    int   mx;
    int   run;
    int   gap;
    int   mode;     // 0: ctx = beat index, 1: beat 1 forced to ctx 7
    int   exp_str;
    logic exp_err;
  } vec_t;

  bent_t ent [16];
  int    gaps[16];
  vec_t  vt  [7];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_entries(input int cnt, input int mode, input int gap, input bit rnd);
    logic [63:0] r;
    for (int i = 0; i < cnt; i++) begin
      r = {$urandom(), $urandom()};
      ent[i] = r[49:0];
      if (rnd) begin
        gaps[i] = $urandom_range(0, 3);
      end else begin
        gaps[i] = gap;
        ent[i].ctx = 4'(i);
        if (mode == 1 && i == 1) ent[i].ctx = 4'd7;
      end
    end
  endtask

  task automatic run_job(input int cnt, input int mx, input int run, input int exp_str,
                         input logic exp_err, input string tag);
    int   nstr;
    logic ok;
    nstr = 0;
    chk({tag, ":cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_entry_count = 8'(cnt);
    cmd_context_max_id = 4'(mx);
    cmd_run_cycles = 16'(run);
    step();
    cmd_valid = 1'b0;
    chk({tag, ":busy_accept"}, 64'(busy), 64'd1);
    chk({tag, ":cmd_ready_accept"}, 64'(cmd_ready), 64'd0);
    chk({tag, ":max_id"}, 64'(mapping_context_max_id), 64'(mx));
    chk({tag, ":err_cleared"}, 64'(cfg_error), 64'd0);
    chk({tag, ":cfg_ready_accept"}, 64'(cfg_ready), 64'(cnt != 0));
    for (int i = 0; i < cnt; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        step();
        chk({tag, ":gap_no_strobe"}, 64'(write_config_data), 64'd0);
        chk({tag, ":gap_no_start"}, 64'(start_exec), 64'd0);
      end
      cfg_valid = 1'b1;
      {cfg_row, cfg_col, cfg_in1, cfg_in2, cfg_op, cfg_const, cfg_context} = ent[i];
      chk({tag, ":cfg_ready"}, 64'(cfg_ready), 64'd1);
      step();
      cfg_valid = 1'b0;
      ok = (int'(ent[i].ctx) <= mx);
      chk({tag, ":strobe"}, 64'(write_config_data), 64'(ok));
      if (write_config_data) nstr++;
      if (ok)
        chk({tag, ":bus"}, 64'({config_PE_row_index, config_PE_column_index, config_input_PE_index_1,
                                config_input_PE_index_2, config_op, config_const_data, config_index}),
            64'(ent[i]));
    end
    chk({tag, ":strobe_count"}, 64'(nstr), 64'(exp_str));
    chk({tag, ":start_low_after_load"}, 64'(start_exec), 64'd0);
    if (run == 0) begin
      chk({tag, ":done_now"}, 64'(done), 64'd1);
    end else begin
      chk({tag, ":no_early_done"}, 64'(done), 64'd0);
      for (int r = 0; r < run; r++) begin
        step();
        chk({tag, ":start_high"}, 64'(start_exec), 64'd1);
        chk({tag, ":done_low_run"}, 64'(done), 64'd0);
      end
      step();
      chk({tag, ":start_fell"}, 64'(start_exec), 64'd0);
      chk({tag, ":done_pulse"}, 64'(done), 64'd1);
    end
    step();
    chk({tag, ":done_cleared"}, 64'(done), 64'd0);
    chk({tag, ":back_idle"}, 64'(cmd_ready), 64'd1);
    chk({tag, ":busy_cleared"}, 64'(busy), 64'd0);
    chk({tag, ":cfg_error"}, 64'(cfg_error), 64'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   mx, cnt, run, es;
    logic ee;

    vt[0] = '{cnt: 3, mx: 2,  run: 5, gap: 0, mode: 0, exp_str: 3, exp_err: 1'b0};
    vt[1] = '{cnt: 2, mx: 5,  run: 1, gap: 4, mode: 0, exp_str: 2, exp_err: 1'b0};
    vt[2] = '{cnt: 3, mx: 2,  run: 2, gap: 1, mode: 1, exp_str: 2, exp_err: 1'b1};
    vt[3] = '{cnt: 0, mx: 0,  run: 0, gap: 0, mode: 0, exp_str: 0, exp_err: 1'b0};
    vt[4] = '{cnt: 0, mx: 4,  run: 3, gap: 0, mode: 0, exp_str: 0, exp_err: 1'b0};
    vt[5] = '{cnt: 1, mx: 15, run: 0, gap: 2, mode: 0, exp_str: 1, exp_err: 1'b0};
    vt[6] = '{cnt: 4, mx: 0,  run: 2, gap: 0, mode: 0, exp_str: 1, exp_err: 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    cmd_entry_count = '0; cmd_context_max_id = '0; cmd_run_cycles = '0;
    {cfg_row, cfg_col, cfg_in1, cfg_in2, cfg_op, cfg_const, cfg_context} = '0;
    repeat (3) step();
    chk("reset_outputs", 64'({cmd_ready, cfg_ready, write_config_data, start_exec, busy, done,
                              aborted, cfg_error, mapping_context_max_id, config_index}), 64'd0);
    chk("reset_const", 64'(config_const_data), 64'd0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int v = 0; v < 7; v++) begin
      fill_entries(vt[v].cnt, vt[v].mode, vt[v].gap, 1'b0);
      run_job(vt[v].cnt, vt[v].mx, vt[v].run, vt[v].exp_str, vt[v].exp_err, $sformatf("vec%0d", v));
    end

    for (int j = 0; j < 20; j++) begin
      cnt = $urandom_range(0, 5);
      mx  = $urandom_range(0, 15);
      run = $urandom_range(0, 8);
      fill_entries(cnt, 0, 0, 1'b1);
      es = 0; ee = 1'b0;
      for (int i = 0; i < cnt; i++) begin
        if (int'(ent[i].ctx) <= mx) es++;
        else ee = 1'b1;
      end
      run_job(cnt, mx, run, es, ee, $sformatf("rnd%0d", j));
    end

    // abort ignored while idle
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_ignored", 64'(aborted), 64'd0);
    chk("idle_abort_ready", 64'(cmd_ready), 64'd1);

    // abort during RUN cycle 2
    fill_entries(1, 0, 0, 1'b0);
    cmd_valid = 1'b1; cmd_entry_count = 8'd1; cmd_context_max_id = 4'd3; cmd_run_cycles = 16'd6;
    step();
    cmd_valid = 1'b0;
    cfg_valid = 1'b1;
    {cfg_row, cfg_col, cfg_in1, cfg_in2, cfg_op, cfg_const, cfg_context} = ent[0];
    step();
    cfg_valid = 1'b0;
    chk("ab_strobe", 64'(write_config_data), 64'd1);
    step();
    chk("ab_run1", 64'(start_exec), 64'd1);
    step();
    chk("ab_run2", 64'(start_exec), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_start_low", 64'(start_exec), 64'd0);
    chk("ab_pulse", 64'(aborted), 64'd1);
    chk("ab_no_done", 64'(done), 64'd0);
    chk("ab_idle", 64'({cmd_ready, busy}), 64'b10);
    es = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done || start_exec || aborted) es++;
    end
    chk("ab_quiet_after", 64'(es), 64'd0);

    // abort coincident with command handshake drops the command
    cmd_valid = 1'b1; abort = 1'b1;
    cmd_entry_count = 8'd2; cmd_context_max_id = 4'd9; cmd_run_cycles = 16'd4;
    step();
    cmd_valid = 1'b0; abort = 1'b0;
    chk("drop_aborted", 64'(aborted), 64'd1);
    chk("drop_not_busy", 64'({busy, cfg_ready, cmd_ready}), 64'b001);
    chk("drop_max_held", 64'(mapping_context_max_id), 64'd3);
    step();
    chk("drop_pulse_end", 64'(aborted), 64'd0);

    // reset asserted mid-LOAD clears outputs without waiting for a clock
    cmd_valid = 1'b1; cmd_entry_count = 8'd3; cmd_context_max_id = 4'd1; cmd_run_cycles = 16'd2;
    step();
    cmd_valid = 1'b0;
    cfg_valid = 1'b1; cfg_context = 4'd5;
    step();
    cfg_context = 4'd1;
    step();
    cfg_valid = 1'b0;
    chk("rst_pre_strobe", 64'({write_config_data, cfg_error}), 64'b11);
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", 64'({cmd_ready, cfg_ready, write_config_data, start_exec, busy, done,
                                  aborted, cfg_error, mapping_context_max_id, config_index}), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("rst_recover", 64'({cmd_ready, busy}), 64'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
